// File: rtl/stopwatch_display.sv
// Stopwatch display stage: clamps and converts binary MM:SS to BCD with a
// free-running shift-add-3 converter, then scans a 4-digit common-anode
// 7-segment display and blinks it while paused.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   minutes[7:0]        binary minutes (>99 displayed as 99)
//   seconds[5:0]        binary seconds (>59 displayed as 59)
//   status[1:0]         00 idle, 01 running, 10 paused, 11 idle
//   an[3:0]             digit enables, active-low (an[0] = seconds ones)
//   seg[6:0]            segments {g,f,e,d,c,b,a}, active-low
//   dp_n                decimal point, active-low, lit on the minutes-ones digit
//   ovf                 committed minutes snapshot was above 99
module stopwatch_display #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] minutes,
   input  logic [5:0] seconds,
   input  logic [1:0] status,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp_n,
   output logic       ovf
);

   localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
   localparam logic [1:0] ST_PAUSED = 2'b10;
   localparam logic [2:0] LAST_SHIFT = 3'd6;

   typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_COMMIT} conv_state_t;

   conv_state_t r_state;
   conv_state_t w_state_nxt;
   logic        w_load;
   logic        w_shift;
   logic        w_commit;

   // Engine layout: {bcd tens[14:11], bcd ones[10:7], binary[6:0]}
   logic [14:0] r_min_eng;
   logic [14:0] r_sec_eng;
   logic        r_ovf_snap;
   logic [2:0]  r_shift_cnt;
   logic [7:0]  r_disp_min;
   logic [7:0]  r_disp_sec;

   logic [REF_W-1:0] r_pre;
   logic [1:0]       r_idx;
   logic [BLK_W-1:0] r_blink_cnt;
   logic             r_blink_phase;

   logic [6:0] w_min_clamp;
   logic [5:0] w_sec_clamp;
   logic       w_tick;
   logic       w_paused;
   logic [3:0] w_digit;
   logic [6:0] w_seg;

   // One shift-add-3 step: correct nibbles >=5, then shift left
   function automatic logic [14:0] dabble(input logic [14:0] v);
      logic [14:0] t;
      t = v;
      if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
      if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
      return {t[13:0], 1'b0};
   endfunction

   // BCD digit to active-low segments; non-BCD blanks
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign w_min_clamp = (minutes > 8'd99) ? 7'd99 : minutes[6:0];
   assign w_sec_clamp = (seconds > 6'd59) ? 6'd59 : seconds;
   assign w_tick      = (r_pre == REF_LAST);
   assign w_paused    = (status == ST_PAUSED);

   // Converter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_LOAD;
      else        r_state <= w_state_nxt;
   end

   // Converter next state: LOAD -> 7x SHIFT -> COMMIT -> LOAD
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:   w_state_nxt = S_SHIFT;
         S_SHIFT:  if (r_shift_cnt == LAST_SHIFT) w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_LOAD;
         default:  w_state_nxt = S_LOAD;
      endcase
   end

   // Converter control decode
   always_comb begin
      w_load   = 1'b0;
      w_shift  = 1'b0;
      w_commit = 1'b0;
      case (r_state)
         S_LOAD:   w_load   = 1'b1;
         S_SHIFT:  w_shift  = 1'b1;
         S_COMMIT: w_commit = 1'b1;
         default:  w_load   = 1'b0;
      endcase
   end

   // Converter datapath and display registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_min_eng   <= '0;
         r_sec_eng   <= '0;
         r_ovf_snap  <= 1'b0;
         r_shift_cnt <= '0;
         r_disp_min  <= '0;
         r_disp_sec  <= '0;
         ovf         <= 1'b0;
      end else begin
         if (w_load) begin
            r_min_eng   <= {8'd0, w_min_clamp};
            r_sec_eng   <= {9'd0, w_sec_clamp};
            r_ovf_snap  <= (minutes > 8'd99);
            r_shift_cnt <= '0;
         end
         if (w_shift) begin
            r_min_eng   <= dabble(r_min_eng);
            r_sec_eng   <= dabble(r_sec_eng);
            r_shift_cnt <= r_shift_cnt + 3'd1;
         end
         if (w_commit) begin
            r_disp_min <= r_min_eng[14:7];
            r_disp_sec <= r_sec_eng[14:7];
            ovf        <= r_ovf_snap;
         end
      end
   end

   // Blink counter: held visible unless paused
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (!w_paused) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (r_blink_cnt == BLK_LAST) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt   <= r_blink_cnt + BLK_W'(1);
      end
   end

   // Digit currently addressed by the scan index
   always_comb begin
      w_digit = 4'd0;
      case (r_idx)
         2'd0:    w_digit = r_disp_sec[3:0];
         2'd1:    w_digit = r_disp_sec[7:4];
         2'd2:    w_digit = r_disp_min[3:0];
         default: w_digit = r_disp_min[7:4];
      endcase
   end

   assign w_seg = seg_decode(w_digit);

   // Scan: r_idx is the digit shown at the next tick, so the first tick after
   // reset shows idx0; outputs change only on ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_idx <= '0;
         an    <= 4'b1111;
         seg   <= 7'h7F;
         dp_n  <= 1'b1;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + REF_W'(1);
         if (w_tick) begin
            r_idx <= r_idx + 2'd1;
            if (r_blink_phase) begin
               an   <= ~(4'b0001 << r_idx);
               seg  <= w_seg;
               dp_n <= (r_idx != 2'd2);
            end else begin
               an   <= 4'b1111;
               seg  <= 7'h7F;
               dp_n <= 1'b1;
            end
         end
      end
   end

endmodule
